// File: rtl/inlet_ctrl_pkg.sv
// Shared types and defaults for the inlet dispense sequencer.
// Used with the optional DISPENSE_ABORT_EN build of inlet_dispense_ctrl.
package inlet_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        PUMP_HI = 3'd2,
        PUMP_LO = 3'd3,
        RESIDE  = 3'd4,
        DONE    = 3'd5
    } inlet_state_t;

    localparam int STEP_W_DEF           = 16;
    localparam int SETTLE_CYCLES_DEF    = 16;
    localparam int STEP_HI_DEF          = 2;
    localparam int STEP_LO_DEF          = 2;
    localparam int RESIDENCE_CYCLES_DEF = 256;

    // Wide enough to hold the longest phase length as a load value.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

    localparam int TIMER_W_DEF = timer_width(SETTLE_CYCLES_DEF, STEP_HI_DEF,
                                             STEP_LO_DEF, RESIDENCE_CYCLES_DEF);

endpackage

// File: rtl/inlet_dispense_ctrl_cycle_timer.sv
// Loadable down-counter shared by every timed phase of the dispense sequencer.
// A start pulse makes expired rise exactly load cycles later (load >= 1).
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= load - 1'b1;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/inlet_dispense_ctrl.sv
// Inlet valve / pump step sequencer feeding the serpentine mixing chain.
// Optional abort input and aborted flag are built when DISPENSE_ABORT_EN is defined.
module inlet_dispense_ctrl
    import inlet_ctrl_pkg::*;
#(
    parameter int STEP_W           = STEP_W_DEF,
    parameter int SETTLE_CYCLES    = SETTLE_CYCLES_DEF,
    parameter int STEP_HI          = STEP_HI_DEF,
    parameter int STEP_LO          = STEP_LO_DEF,
    parameter int RESIDENCE_CYCLES = RESIDENCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [STEP_W-1:0] req_steps,
`ifdef DISPENSE_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              valve_open,
    output logic              pump_step,
    output logic              busy,
    output logic              done_pulse,
    output logic [STEP_W-1:0] dispensed_steps
);

    localparam int TIMER_W = timer_width(SETTLE_CYCLES, STEP_HI, STEP_LO, RESIDENCE_CYCLES);

    inlet_state_t        state_reg, state_next;
    logic [STEP_W-1:0]   count_reg;
    logic [STEP_W-1:0]   dispensed_reg;
    logic                timer_start;
    logic [TIMER_W-1:0]  timer_load;
    logic                timer_expired;
    logic                accept;
    logic                step_done;
    logic                req_ready_reg, valve_open_reg, pump_step_reg, busy_reg, done_pulse_reg;
`ifdef DISPENSE_ABORT_EN
    logic                abort_take;
    logic                aborted_reg;
`endif

    cycle_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (timer_start),
        .load    (timer_load),
        .expired (timer_expired)
    );

    assign accept = req_valid && req_ready_reg;

    always_comb begin
        state_next  = state_reg;
        timer_start = 1'b0;
        timer_load  = '0;
`ifdef DISPENSE_ABORT_EN
        abort_take  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_steps == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next  = SETTLE;
                        timer_start = 1'b1;
                        timer_load  = TIMER_W'(SETTLE_CYCLES);
                    end
                end
            end
            SETTLE: begin
                if (timer_expired) begin
                    state_next  = PUMP_HI;
                    timer_start = 1'b1;
                    timer_load  = TIMER_W'(STEP_HI);
                end
            end
            PUMP_HI: begin
                if (timer_expired) begin
                    state_next  = PUMP_LO;
                    timer_start = 1'b1;
                    timer_load  = TIMER_W'(STEP_LO);
                end
            end
            PUMP_LO: begin
                // dispensed_reg was already bumped on entry to this phase.
                if (timer_expired) begin
                    if (dispensed_reg == count_reg) begin
                        state_next  = RESIDE;
                        timer_start = 1'b1;
                        timer_load  = TIMER_W'(RESIDENCE_CYCLES);
                    end else begin
                        state_next  = PUMP_HI;
                        timer_start = 1'b1;
                        timer_load  = TIMER_W'(STEP_HI);
                    end
                end
            end
            RESIDE: begin
                if (timer_expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef DISPENSE_ABORT_EN
        if (abort && (state_reg == SETTLE || state_reg == PUMP_HI || state_reg == PUMP_LO)) begin
            state_next  = RESIDE;
            timer_start = 1'b1;
            timer_load  = TIMER_W'(RESIDENCE_CYCLES);
            abort_take  = 1'b1;
        end
`endif
    end

    // Any exit from a high phase (normal or aborted) completes one step.
    assign step_done = (state_reg == PUMP_HI) && (state_next != PUMP_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            dispensed_reg  <= '0;
            req_ready_reg  <= 1'b1;
            valve_open_reg <= 1'b0;
            pump_step_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_ready_reg  <= (state_next == IDLE);
            valve_open_reg <= (state_next == SETTLE) || (state_next == PUMP_HI) ||
                              (state_next == PUMP_LO);
            pump_step_reg  <= (state_next == PUMP_HI);
            busy_reg       <= (state_next != IDLE);
            done_pulse_reg <= (state_next == DONE);
            if (accept) begin
                count_reg     <= req_steps;
                dispensed_reg <= '0;
            end else if (step_done) begin
                dispensed_reg <= dispensed_reg + 1'b1;
            end
        end
    end

`ifdef DISPENSE_ABORT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_reg <= 1'b0;
        end else if (accept) begin
            aborted_reg <= 1'b0;
        end else if (abort_take) begin
            aborted_reg <= 1'b1;
        end
    end

    assign aborted = aborted_reg;
`endif

    assign req_ready       = req_ready_reg;
    assign valve_open      = valve_open_reg;
    assign pump_step       = pump_step_reg;
    assign busy            = busy_reg;
    assign done_pulse      = done_pulse_reg;
    assign dispensed_steps = dispensed_reg;

endmodule

// File: tb/tb_inlet_dispense_ctrl.sv
// Scoreboard bench for inlet_dispense_ctrl with SETTLE=4, HI=2, LO=2, RESIDENCE=8.
// Abort scenarios are included when DISPENSE_ABORT_EN is defined.
module tb_inlet_dispense_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_steps = '0;
    logic        valve_open, pump_step, busy, done_pulse;
    logic [15:0] dispensed_steps;
`ifdef DISPENSE_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    inlet_dispense_ctrl #(
        .STEP_W(16), .SETTLE_CYCLES(4), .STEP_HI(2), .STEP_LO(2), .RESIDENCE_CYCLES(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_steps       (req_steps),
`ifdef DISPENSE_ABORT_EN
        .abort           (abort),
        .aborted         (aborted),
`endif
        .valve_open      (valve_open),
        .pump_step       (pump_step),
        .busy            (busy),
        .done_pulse      (done_pulse),
        .dispensed_steps (dispensed_steps)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int vfirst; int vlast; int pfirst; int pcount; int done_cyc; int disp; int abrt;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    function automatic void check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic int rel(input int a, input int off);
        return (off < 0) ? -1 : a + off;
    endfunction

    function automatic void push_exp(input int a, input int vf, input int vl, input int pf,
                                     input int pc, input int dn, input int disp, input int ab);
        exp_t x;
        x.vfirst = rel(a, vf); x.vlast = rel(a, vl); x.pfirst = rel(a, pf);
        x.pcount = pc; x.done_cyc = a + dn; x.disp = disp; x.abrt = ab;
        exp_q.push_back(x);
    endfunction

    // Monitor: track valve/pump activity per transaction, score on done_pulse.
    int   vf = -1, vl = -1, pf = -1, pc = 0;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            vf = -1; vl = -1; pf = -1; pc = 0;
        end else begin
            if (valve_open) begin
                if (vf < 0) vf = cyc;
                vl = cyc;
            end
            if (pump_step) begin
                if (pf < 0) pf = cyc;
                pc++;
            end
            if (done_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("dispensed", int'(dispensed_steps), e.disp);
                    check("valve_first", vf, e.vfirst);
                    check("valve_last", vl, e.vlast);
                    check("pump_first", pf, e.pfirst);
                    check("pump_count", pc, e.pcount);
                    check("done_ready_low", int'(req_ready), 0);
`ifdef DISPENSE_ABORT_EN
                    check("aborted", int'(aborted), e.abrt);
`endif
                    $display("txn: done at cycle %0d dispensed=%0d valve=%0d..%0d pumps=%0d",
                             cyc, dispensed_steps, vf, vl, pc);
                end
                vf = -1; vl = -1; pf = -1; pc = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(req_ready), 1);
    endtask

    task automatic issue(input int n);
        req_valid = 1'b1;
        req_steps = 16'(n);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int a;
        int n;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_valve", int'(valve_open), 0);
        check("rst_pump", int'(pump_step), 0);
        check("rst_done", int'(done_pulse), 0);
        check("rst_dispensed", int'(dispensed_steps), 0);
        rst = 1'b0;
        @(negedge clk);

        // N=3 nominal
        a = cyc; push_exp(a, 1, 16, 5, 6, 25, 3, 0); issue(3); wait_idle();
        // N=0: straight to DONE, valve never opens
        a = cyc; push_exp(a, -1, -1, -1, 0, 1, 0, 0); issue(0); wait_idle();

        // req_valid held through two N=1 requests
        a = cyc;
        push_exp(a, 1, 8, 5, 2, 17, 1, 0);
        push_exp(a, 19, 26, 23, 2, 35, 1, 0);
        req_valid = 1'b1; req_steps = 16'd1;
        repeat (19) @(negedge clk);
        req_valid = 1'b0;
        wait_idle();

        // Reset on cycle 7 of an N=3 run
        a = cyc; issue(3);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valve", int'(valve_open), 0);
        check("midrst_pump", int'(pump_step), 0);
        check("midrst_ready", int'(req_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_dispensed", int'(dispensed_steps), 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // N=2 after reset
        a = cyc; push_exp(a, 1, 12, 5, 4, 21, 2, 0); issue(2); wait_idle();

`ifdef DISPENSE_ABORT_EN
        // Abort during the second high phase
        a = cyc; push_exp(a, 1, 9, 5, 3, 18, 2, 1); issue(3);
        repeat (8) @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_idle();
        check("aborted_hold_idle", int'(aborted), 1);

        // Abort in IDLE and RESIDE is ignored
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("idle_abort_ignored_busy", int'(busy), 0);
        a = cyc; push_exp(a, 1, 16, 5, 6, 25, 3, 0); issue(3);
        check("aborted_cleared_on_accept", int'(aborted), 0);
        repeat (19) @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_idle();
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inlet_dispense_ctrl.md
Name: inlet_dispense_ctrl

Overview:
- Digital sequencer upstream of the serpentine mixing chain. It meters fluid into the chain's inlet by opening the inlet valve, issuing a counted train of pump step pulses, then closing the valve.
- After closing, it waits a fixed residence time so the slug can traverse the serpentines before signalling completion.
- Takes one dispense request at a time over a valid/ready handshake.

Parameters:
- STEP_W, 16, width of requested step count and dispensed count
- SETTLE_CYCLES, 16, cycles the valve is open before the first pump pulse (≥1)
- STEP_HI, 2, cycles pump_step is high per step (≥1)
- STEP_LO, 2, cycles pump_step is low after each high phase (≥1)
- RESIDENCE_CYCLES, 256, cycles with valve closed before done (≥1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  dispense request present
- req_ready  out  1  block can accept a request
- req_steps  in  STEP_W  pump steps to dispense
- valve_open  out  1  inlet valve drive
- pump_step  out  1  pump step pulse
- busy  out  1  high in any state except IDLE
- done_pulse  out  1  one-cycle completion strobe
- dispensed_steps  out  STEP_W  completed pump steps for the current/last request
- abort  in  1  present only with DISPENSE_ABORT_EN
- aborted  out  1  present only with DISPENSE_ABORT_EN

Behaviour:
- Reset: clk and rst only; synchronous, active-high. On reset, state=IDLE and all outputs are 0 except req_ready=1. Reset at any point (including mid-pump) closes the valve and drops pump_step on the next edge, with no done_pulse.
- All outputs are registered, Moore-style, decoded from state.
- FSM states: IDLE, SETTLE, PUMP_HI, PUMP_LO, RESIDE, DONE.
- IDLE:
  - req_ready=1.
  - Accept when req_valid&&req_ready; latch req_steps and clear dispensed_steps.
  - If req_steps==0: go to DONE. The valve never opens.
  - Otherwise: go to SETTLE.
- SETTLE: valve_open=1 for SETTLE_CYCLES cycles, then PUMP_HI.
- PUMP_HI: valve_open=1, pump_step=1 for STEP_HI cycles, then PUMP_LO.
- PUMP_LO:
  - valve_open=1, pump_step=0 for STEP_LO cycles.
  - dispensed_steps increments on entry to PUMP_LO.
  - At the end of PUMP_LO: if dispensed_steps==latched count, go to RESIDE; else go to PUMP_HI.
- RESIDE: valve_open=0 for RESIDENCE_CYCLES cycles, then DONE.
- DONE: done_pulse=1 for exactly one cycle, req_ready=0, then IDLE.
- Timing, with the accept edge as cycle 0 and N=req_steps>0:
  - valve_open high on cycles 1 .. SETTLE+N*(HI+LO)
  - done_pulse on cycle SETTLE+N*(HI+LO)+RESIDENCE+1
  - earliest next accept on the following cycle
- N=0: done_pulse on cycle 1.
- dispensed_steps holds its value after DONE until the next accept. It never exceeds the latched count, so no wrap is possible.
- req_valid while busy is ignored and not buffered. req_steps is sampled only at accept.
- N=2^STEP_W-1 is legal.

Optional Feature:
- Macro: DISPENSE_ABORT_EN.
- With the macro defined:
  - abort sampled high in SETTLE, PUMP_HI or PUMP_LO forces RESIDE on the next edge, so valve_open and pump_step go to 0.
  - A step whose high phase had begun is counted.
  - aborted is set on that edge and held through DONE, then cleared on the next accept or on rst.
  - abort in IDLE, RESIDE or DONE is ignored.
- Without the macro: the abort and aborted ports do not exist and the abort logic is absent.

Decomposition:
- Package inlet_ctrl_pkg holds:
  - state enum inlet_state_t
  - localparam defaults for the widths
  - timer width derived as $clog2 of the largest of SETTLE/HI/LO/RESIDENCE plus 1
- Sub-module cycle_timer: loadable down-counter with a load value, a start pulse and an expired flag. It is shared by all timed states.

Test Plan (all cases use SETTLE=4, HI=2, LO=2, RESIDENCE=8):
- req_steps=3 accepted at cycle 0:
  - valve_open high on cycles 1–16
  - pump_step high on cycles 5–6, 9–10, 13–14
  - done_pulse on cycle 25
  - dispensed_steps=3
- req_steps=0: done_pulse on cycle 1, valve_open and pump_step never assert, dispensed_steps=0.
- req_valid held high with req_steps=1 for two requests: first done at cycle 17, second accepted at cycle 18, second done at cycle 35; requests offered while busy produce no extra pulses.
- rst asserted on cycle 7 of an N=3 run: valve_open=0, pump_step=0, req_ready=1 on the next cycle, and no done_pulse.
- DISPENSE_ABORT_EN, N=3, abort on cycle 9: valve_open=0 from cycle 10, done_pulse on cycle 18, aborted=1, dispensed_steps=2.
- DISPENSE_ABORT_EN, abort pulsed in IDLE and in RESIDE: no effect, aborted=0, nominal timing unchanged.
